// File: rtl/turf_udp_out_arb.sv
// -----------------------------------------------------------------------------
// turf_udp_out_arb
//
// Packet-level round-robin arbiter that merges the per-port outbound UDP
// header/payload stream pairs into the single header/payload pair feeding the
// UDP core. One granted port owns both output streams from header acceptance
// through the payload beat carrying tlast, so packets are never interleaved.
//
// Ports:
//   clk, rst            - clock; asynchronous active-high reset
//   s_hdr_*             - per-port header streams (tdata 64b, tuser 16b)
//   s_payload_*         - per-port payload streams (tdata/tkeep/tlast)
//   m_hdr_*             - merged header stream to the UDP core
//   m_payload_*         - merged payload stream to the UDP core
//   grant               - index of the current or last granted port
//   busy                - high while a packet is being forwarded (HDR/DATA)
// -----------------------------------------------------------------------------
module turf_udp_out_arb #(
   parameter int NUM_PORT      = 5,
   parameter int PAYLOAD_WIDTH = 64
) (
   input  logic                                  clk,
   input  logic                                  rst,

   input  logic [NUM_PORT*64-1:0]                s_hdr_tdata,
   input  logic [NUM_PORT-1:0]                   s_hdr_tvalid,
   output logic [NUM_PORT-1:0]                   s_hdr_tready,
   input  logic [NUM_PORT*16-1:0]                s_hdr_tuser,

   input  logic [NUM_PORT*PAYLOAD_WIDTH-1:0]     s_payload_tdata,
   input  logic [NUM_PORT-1:0]                   s_payload_tvalid,
   output logic [NUM_PORT-1:0]                   s_payload_tready,
   input  logic [NUM_PORT*PAYLOAD_WIDTH/8-1:0]   s_payload_tkeep,
   input  logic [NUM_PORT-1:0]                   s_payload_tlast,

   output logic [63:0]                           m_hdr_tdata,
   output logic                                  m_hdr_tvalid,
   input  logic                                  m_hdr_tready,
   output logic [15:0]                           m_hdr_tuser,

   output logic [PAYLOAD_WIDTH-1:0]              m_payload_tdata,
   output logic                                  m_payload_tvalid,
   input  logic                                  m_payload_tready,
   output logic [PAYLOAD_WIDTH/8-1:0]            m_payload_tkeep,
   output logic                                  m_payload_tlast,

   output logic [$clog2(NUM_PORT)-1:0]           grant,
   output logic                                  busy
);

   localparam int KEEP_WIDTH = PAYLOAD_WIDTH / 8;
   localparam int GW         = $clog2(NUM_PORT);

   typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

   state_t        state;
   logic [GW-1:0] next_grant;

   logic          sel_hdr_tvalid;
   logic          sel_payload_tvalid;

   // Round-robin search starting at grant+1. Walking the offsets from the
   // farthest to the nearest lets the nearest requester overwrite the others,
   // so the port that just finished (offset NUM_PORT) has the lowest priority.
   always_comb begin : arb_search
      int            cand;
      logic [GW-1:0] idx;
      // NOTE: every always_comb output gets a default first so no path leaves
      // it unassigned, which would infer a latch.
      cand       = 0;
      idx        = '0;
      next_grant = grant;
      for (int i = NUM_PORT; i >= 1; i--) begin
         cand = int'(grant) + i;
         if (cand >= NUM_PORT) cand = cand - NUM_PORT;
         idx = GW'(cand);
         if (s_hdr_tvalid[idx]) next_grant = idx;
      end
   end

   // Output muxes follow grant in every state; the valids are then gated by
   // state so stale data while valid is low is harmless.
   always_comb begin : out_mux
      m_hdr_tdata        = '0;
      m_hdr_tuser        = '0;
      sel_hdr_tvalid     = 1'b0;
      m_payload_tdata    = '0;
      m_payload_tkeep    = '0;
      m_payload_tlast    = 1'b0;
      sel_payload_tvalid = 1'b0;
      s_hdr_tready       = '0;
      s_payload_tready   = '0;
      for (int p = 0; p < NUM_PORT; p++) begin
         if (grant == GW'(p)) begin
            m_hdr_tdata        = s_hdr_tdata[64*p +: 64];
            m_hdr_tuser        = s_hdr_tuser[16*p +: 16];
            sel_hdr_tvalid     = s_hdr_tvalid[p];
            m_payload_tdata    = s_payload_tdata[PAYLOAD_WIDTH*p +: PAYLOAD_WIDTH];
            m_payload_tkeep    = s_payload_tkeep[KEEP_WIDTH*p +: KEEP_WIDTH];
            m_payload_tlast    = s_payload_tlast[p];
            sel_payload_tvalid = s_payload_tvalid[p];
            s_hdr_tready[p]     = (state == HDR)  && m_hdr_tready;
            s_payload_tready[p] = (state == DATA) && m_payload_tready;
         end
      end
      m_hdr_tvalid     = (state == HDR)  && sel_hdr_tvalid;
      m_payload_tvalid = (state == DATA) && sel_payload_tvalid;
   end

   // Packet FSM. Reset parks grant on the last port so port 0 wins first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: state registers use non-blocking assignments so every flop
         // samples pre-edge values regardless of statement order.
         state <= IDLE;
         grant <= GW'(NUM_PORT - 1);
         busy  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|s_hdr_tvalid) begin
                  grant <= next_grant;
                  state <= HDR;
                  busy  <= 1'b1;
               end
            end
            HDR: begin
               if (m_hdr_tvalid && m_hdr_tready) state <= DATA;
            end
            DATA: begin
               if (m_payload_tvalid && m_payload_tready && m_payload_tlast) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_turf_udp_out_arb.sv
// -----------------------------------------------------------------------------
// tb_turf_udp_out_arb
//
// Self-checking bench for turf_udp_out_arb: a table of single-port packets
// with hand-computed expectations, then directed sequences for arbitration
// order, backpressure, a delayed payload and reset in mid-packet.
// -----------------------------------------------------------------------------
module tb_turf_udp_out_arb;

   localparam int NP = 5;
   localparam int PW = 64;
   localparam int KW = PW / 8;
   localparam int GW = $clog2(NP);

   logic              clk = 1'b0;
   logic              rst;
   logic [NP*64-1:0]  s_hdr_tdata;
   logic [NP-1:0]     s_hdr_tvalid;
   logic [NP-1:0]     s_hdr_tready;
   logic [NP*16-1:0]  s_hdr_tuser;
   logic [NP*PW-1:0]  s_payload_tdata;
   logic [NP-1:0]     s_payload_tvalid;
   logic [NP-1:0]     s_payload_tready;
   logic [NP*KW-1:0]  s_payload_tkeep;
   logic [NP-1:0]     s_payload_tlast;
   logic [63:0]       m_hdr_tdata;
   logic              m_hdr_tvalid;
   logic              m_hdr_tready;
   logic [15:0]       m_hdr_tuser;
   logic [PW-1:0]     m_payload_tdata;
   logic              m_payload_tvalid;
   logic              m_payload_tready;
   logic [KW-1:0]     m_payload_tkeep;
   logic              m_payload_tlast;
   logic [GW-1:0]     grant;
   logic              busy;

   turf_udp_out_arb #(.NUM_PORT(NP), .PAYLOAD_WIDTH(PW)) dut (
      .clk              (clk),
      .rst              (rst),
      .s_hdr_tdata      (s_hdr_tdata),
      .s_hdr_tvalid     (s_hdr_tvalid),
      .s_hdr_tready     (s_hdr_tready),
      .s_hdr_tuser      (s_hdr_tuser),
      .s_payload_tdata  (s_payload_tdata),
      .s_payload_tvalid (s_payload_tvalid),
      .s_payload_tready (s_payload_tready),
      .s_payload_tkeep  (s_payload_tkeep),
      .s_payload_tlast  (s_payload_tlast),
      .m_hdr_tdata      (m_hdr_tdata),
      .m_hdr_tvalid     (m_hdr_tvalid),
      .m_hdr_tready     (m_hdr_tready),
      .m_hdr_tuser      (m_hdr_tuser),
      .m_payload_tdata  (m_payload_tdata),
      .m_payload_tvalid (m_payload_tvalid),
      .m_payload_tready (m_payload_tready),
      .m_payload_tkeep  (m_payload_tkeep),
      .m_payload_tlast  (m_payload_tlast),
      .grant            (grant),
      .busy             (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          port;
      logic [63:0] hdr;
      logic [15:0] tuser;
      int          nbeats;
      logic [7:0]  last_keep;
   } pkt_t;

   pkt_t tbl[6];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   // Drive just after the rising edge, sample on the falling edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic mid;
      @(negedge clk);
   endtask

   function automatic logic [63:0] beat_data(input int p, input int b);
      return 64'hD00D_0000_0000_0000 | (64'(p) << 16) | 64'(b);
   endfunction

   task automatic clear_inputs;
      s_hdr_tdata      = '0;
      s_hdr_tvalid     = '0;
      s_hdr_tuser      = '0;
      s_payload_tdata  = '0;
      s_payload_tvalid = '0;
      s_payload_tkeep  = '0;
      s_payload_tlast  = '0;
   endtask

   task automatic do_reset;
      clear_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic set_hdr(input int p, input logic [63:0] h, input logic [15:0] u);
      s_hdr_tvalid[p]         = 1'b1;
      s_hdr_tdata[64*p +: 64] = h;
      s_hdr_tuser[16*p +: 16] = u;
   endtask

   task automatic set_beat(input int p, input int k, input int n, input logic [7:0] last_keep);
      s_payload_tvalid[p]         = 1'b1;
      s_payload_tdata[PW*p +: PW] = beat_data(p, k);
      s_payload_tkeep[KW*p +: KW] = (k == n - 1) ? last_keep : 8'hFF;
      s_payload_tlast[p]          = (k == n - 1);
   endtask

   // Sends one packet from a single port with both master readies high.
   task automatic send_pkt(input pkt_t t, input string tag);
      int p;
      p = t.port;
      set_hdr(p, t.hdr, t.tuser);
      mid();
      check({tag, " idle m_hdr_tvalid"}, 64'(m_hdr_tvalid), 64'd0);
      check({tag, " idle busy"}, 64'(busy), 64'd0);
      check({tag, " idle s_hdr_tready"}, 64'(s_hdr_tready), 64'd0);
      tick();
      mid();
      check({tag, " hdr m_hdr_tvalid"}, 64'(m_hdr_tvalid), 64'd1);
      check({tag, " hdr m_hdr_tdata"}, m_hdr_tdata, t.hdr);
      check({tag, " hdr m_hdr_tuser"}, 64'(m_hdr_tuser), 64'(t.tuser));
      check({tag, " hdr grant"}, 64'(grant), 64'(p));
      check({tag, " hdr s_hdr_tready"}, 64'(s_hdr_tready), 64'd1 << p);
      check({tag, " hdr busy"}, 64'(busy), 64'd1);
      tick();
      s_hdr_tvalid[p] = 1'b0;
      for (int b = 0; b < t.nbeats; b++) begin
         set_beat(p, b, t.nbeats, t.last_keep);
         mid();
         check({tag, " data tvalid"}, 64'(m_payload_tvalid), 64'd1);
         check({tag, " data tdata"}, m_payload_tdata, beat_data(p, b));
         check({tag, " data tkeep"}, 64'(m_payload_tkeep),
               (b == t.nbeats - 1) ? 64'(t.last_keep) : 64'hFF);
         check({tag, " data tlast"}, 64'(m_payload_tlast), 64'(b == t.nbeats - 1));
         check({tag, " data s_payload_tready"}, 64'(s_payload_tready), 64'd1 << p);
         check({tag, " data s_hdr_tready"}, 64'(s_hdr_tready), 64'd0);
         check({tag, " data m_hdr_tvalid"}, 64'(m_hdr_tvalid), 64'd0);
         tick();
      end
      s_payload_tvalid[p] = 1'b0;
      s_payload_tlast[p]  = 1'b0;
   endtask

   initial begin
      int order[$];
      int cyc[$];
      int exp_order[4];
      int viol;
      int k;
      int beats_out;
      bit done;
      bit hs;

      // Reset with every input asserted: nothing may leak through.
      m_hdr_tready     = 1'b1;
      m_payload_tready = 1'b1;
      rst              = 1'b1;
      s_hdr_tdata      = '1;
      s_hdr_tvalid     = '1;
      s_hdr_tuser      = '1;
      s_payload_tdata  = '1;
      s_payload_tvalid = '1;
      s_payload_tkeep  = '1;
      s_payload_tlast  = '1;
      #12;
      check("rst grant", 64'(grant), 64'(NP - 1));
      check("rst busy", 64'(busy), 64'd0);
      check("rst s_hdr_tready", 64'(s_hdr_tready), 64'd0);
      check("rst s_payload_tready", 64'(s_payload_tready), 64'd0);
      check("rst m_hdr_tvalid", 64'(m_hdr_tvalid), 64'd0);
      check("rst m_payload_tvalid", 64'(m_payload_tvalid), 64'd0);
      do_reset();

      // Single-port packet table.
      tbl[0] = '{port: 2, hdr: 64'h0A0B0C0D_5477_0010, tuser: 16'd21623, nbeats: 2, last_keep: 8'h0F};
      tbl[1] = '{port: 0, hdr: 64'h1000_0000_0000_0001, tuser: 16'h0100, nbeats: 1, last_keep: 8'hFF};
      tbl[2] = '{port: 0, hdr: 64'h1000_0000_0000_0002, tuser: 16'h0101, nbeats: 1, last_keep: 8'h03};
      tbl[3] = '{port: 0, hdr: 64'h1000_0000_0000_0003, tuser: 16'h0102, nbeats: 1, last_keep: 8'h7F};
      tbl[4] = '{port: 4, hdr: 64'h4444_5555_6666_7777, tuser: 16'hA5A5, nbeats: 3, last_keep: 8'h01};
      tbl[5] = '{port: 3, hdr: 64'hFEDC_BA98_7654_3210, tuser: 16'h5A5A, nbeats: 2, last_keep: 8'h3F};
      for (int i = 0; i < 6; i++) send_pkt(tbl[i], $sformatf("tbl%0d", i));
      mid();
      check("tbl end busy", 64'(busy), 64'd0);
      check("tbl end m_payload_tvalid", 64'(m_payload_tvalid), 64'd0);
      tick();

      // Ports 0, 1 and 4 request continuously with 1-beat packets.
      do_reset();
      exp_order = '{0, 1, 4, 0};
      viol = 0;
      foreach (exp_order[i]) begin
         if (i < 3) begin
            set_hdr(exp_order[i], 64'hC0DE_0000_0000_0000 | 64'(exp_order[i]), 16'(100 + exp_order[i]));
            set_beat(exp_order[i], 0, 1, 8'hFF);
         end
      end
      for (int c = 0; c < 16 && order.size() < 4; c++) begin
         mid();
         if (((s_hdr_tready | s_payload_tready) & ~(NP'(1) << grant)) != '0) viol++;
         if (m_hdr_tvalid && m_hdr_tready) begin
            order.push_back(int'(grant));
            cyc.push_back(c);
         end
         tick();
      end
      check("rr handshake count", 64'(order.size()), 64'd4);
      for (int i = 0; i < order.size(); i++) begin
         check($sformatf("rr order[%0d]", i), 64'(order[i]), 64'(exp_order[i]));
         if (i > 0) check($sformatf("rr gap[%0d]", i), 64'(cyc[i] - cyc[i-1]), 64'd3);
      end
      check("rr non-granted readies", 64'(viol), 64'd0);

      // Backpressure on header then toggling payload ready, port 1, 4 beats.
      do_reset();
      m_hdr_tready     = 1'b0;
      m_payload_tready = 1'b1;
      set_hdr(1, 64'h1111_2222_3333_4444, 16'hBEEF);
      mid();
      tick();
      for (int c = 0; c < 3; c++) begin
         mid();
         check("bp hdr stall tvalid", 64'(m_hdr_tvalid), 64'd1);
         check("bp hdr stall tdata", m_hdr_tdata, 64'h1111_2222_3333_4444);
         check("bp hdr stall s_hdr_tready", 64'(s_hdr_tready), 64'd0);
         tick();
      end
      m_hdr_tready = 1'b1;
      mid();
      check("bp hdr s_hdr_tready", 64'(s_hdr_tready), 64'd2);
      check("bp hdr tuser", 64'(m_hdr_tuser), 64'hBEEF);
      tick();
      s_hdr_tvalid[1] = 1'b0;
      k         = 0;
      beats_out = 0;
      done      = 1'b0;
      set_beat(1, 0, 4, 8'h0F);
      for (int c = 0; c < 20 && !done; c++) begin
         mid();
         check("bp ready mirror", 64'(s_payload_tready), 64'(m_payload_tready) << 1);
         check("bp data valid", 64'(m_payload_tvalid), 64'd1);
         check("bp data", m_payload_tdata, beat_data(1, k));
         hs = m_payload_tvalid && m_payload_tready;
         if (hs) begin
            beats_out++;
            if (m_payload_tlast) done = 1'b1;
         end
         tick();
         if (hs) begin
            k++;
            if (k < 4) set_beat(1, k, 4, 8'h0F);
            else begin
               s_payload_tvalid[1] = 1'b0;
               s_payload_tlast[1]  = 1'b0;
            end
         end
         m_payload_tready = ~m_payload_tready;
      end
      check("bp finished in budget", 64'(done), 64'd1);
      check("bp beats out", 64'(beats_out), 64'd4);
      mid();
      check("bp idle busy", 64'(busy), 64'd0);
      tick();

      // Port 3 payload delayed while port 1 requests.
      do_reset();
      m_hdr_tready     = 1'b1;
      m_payload_tready = 1'b1;
      set_hdr(3, 64'h3333_0000_0000_0033, 16'h0333);
      mid();
      tick();
      mid();
      check("dly hdr grant", 64'(grant), 64'd3);
      tick();
      s_hdr_tvalid[3] = 1'b0;
      set_hdr(1, 64'h1111_0000_0000_0011, 16'h0111);
      for (int c = 0; c < 5; c++) begin
         mid();
         check("dly hold grant", 64'(grant), 64'd3);
         check("dly busy", 64'(busy), 64'd1);
         check("dly m_payload_tvalid", 64'(m_payload_tvalid), 64'd0);
         check("dly s_hdr_tready", 64'(s_hdr_tready), 64'd0);
         tick();
      end
      set_beat(3, 0, 1, 8'hFF);
      mid();
      check("dly last s_payload_tready", 64'(s_payload_tready), 64'd8);
      check("dly last busy", 64'(busy), 64'd1);
      tick();
      s_payload_tvalid[3] = 1'b0;
      mid();
      check("dly turnaround busy", 64'(busy), 64'd0);
      check("dly turnaround m_hdr_tvalid", 64'(m_hdr_tvalid), 64'd0);
      tick();
      mid();
      check("dly port1 grant", 64'(grant), 64'd1);
      check("dly port1 m_hdr_tvalid", 64'(m_hdr_tvalid), 64'd1);
      check("dly port1 s_hdr_tready", 64'(s_hdr_tready), 64'd2);
      tick();

      // Reset asserted during beat 2 of a 4-beat packet from port 2.
      do_reset();
      set_hdr(2, 64'h2222_0000_0000_0022, 16'h0222);
      mid();
      tick();
      mid();
      tick();
      s_hdr_tvalid[2] = 1'b0;
      for (int b = 0; b < 2; b++) begin
         set_beat(2, b, 4, 8'hFF);
         tick();
      end
      set_beat(2, 2, 4, 8'hFF);
      mid();
      check("mrst beat2 s_payload_tready", 64'(s_payload_tready), 64'd4);
      #2;
      s_hdr_tvalid[0] = 1'b1;
      rst = 1'b1;
      #1;
      check("mrst s_payload_tready", 64'(s_payload_tready), 64'd0);
      check("mrst m_payload_tvalid", 64'(m_payload_tvalid), 64'd0);
      check("mrst s_hdr_tready", 64'(s_hdr_tready), 64'd0);
      check("mrst busy", 64'(busy), 64'd0);
      check("mrst grant", 64'(grant), 64'(NP - 1));
      s_payload_tvalid[2] = 1'b0;
      s_payload_tlast[2]  = 1'b0;
      @(posedge clk);
      #3;
      rst = 1'b0;
      mid();
      check("mrst post idle m_hdr_tvalid", 64'(m_hdr_tvalid), 64'd0);
      check("mrst post grant", 64'(grant), 64'(NP - 1));
      tick();
      mid();
      check("mrst port0 grant", 64'(grant), 64'd0);
      check("mrst port0 m_hdr_tvalid", 64'(m_hdr_tvalid), 64'd1);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
